// File: rtl/encoder8to3_scan_pkg.sv
// Shared types and default widths for the sequential 8-to-3 scan encoder.
package encoder_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/encoder8to3_scan_if.sv
// Request-in / index-out handshake bundle for encoder8to3_scan.
interface encoder8to3_scan_if
  import encoder_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  d;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] y;
  logic             last;
  logic             zero;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, y, last, zero
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, y, last, zero
  );

endinterface

// File: rtl/encoder8to3_scan_prio.sv
// Combinational priority pick: index and one-hot of the winning set bit.
// Lowest bit wins by default; ENCODER_MSB_PRIORITY_EN makes the highest bit win.
module encoder8to3_prio
  import encoder_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic [IN_W-1:0]  mask_i,
  output logic [OUT_W-1:0] idx_o,
  output logic [IN_W-1:0]  onehot_o
);

  // Later loop iterations overwrite earlier ones, so the scan direction
  // is the reverse of the priority direction.
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
`ifdef ENCODER_MSB_PRIORITY_EN
    for (int i = 0; i < IN_W; i++) begin
      if (mask_i[i]) begin
        idx_o       = OUT_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
`else
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o       = OUT_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/encoder8to3_scan.sv
// Sequential 8-to-3 encoder: captures a request vector, then streams one
// index per handshake. Scan direction set by ENCODER_MSB_PRIORITY_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a vector, in_ready follows en
// ST_SCAN | presenting indices of remaining set bits (or one zero beat)
module encoder8to3_scan
  import encoder_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  encoder8to3_scan_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'(ST_IDLE);
  localparam logic [0:0] S_SCAN = 1'(ST_SCAN);

  logic [0:0]      state_q, state_d;
  logic [IN_W-1:0] mask_q, mask_d;
  logic            zflag_q, zflag_d;

  logic [OUT_W-1:0] prio_idx;
  logic [IN_W-1:0]  prio_oh;
  logic             scanning;
  logic             beat_last;

  encoder8to3_prio #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_prio (
    .mask_i   (mask_q),
    .idx_o    (prio_idx),
    .onehot_o (prio_oh)
  );

  assign scanning  = (state_q == S_SCAN);
  // A lone remaining bit equals its own one-hot pick.
  assign beat_last = zflag_q || (mask_q == prio_oh);

  assign bus.in_ready  = en && !scanning;
  assign bus.out_valid = en && scanning;
  assign bus.y         = (bus.out_valid && !zflag_q) ? prio_idx : '0;
  assign bus.last      = bus.out_valid && beat_last;
  assign bus.zero      = bus.out_valid && zflag_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zflag_d = zflag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_ready && bus.in_valid) begin
          mask_d  = bus.d;
          zflag_d = (bus.d == '0);
          state_d = S_SCAN;
        end
      end
      default: begin
        if (bus.out_valid && bus.out_ready) begin
          mask_d = mask_q & ~prio_oh;
          if (beat_last) begin
            state_d = S_IDLE;
            mask_d  = '0;
            zflag_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zflag_q <= zflag_d;
    end
  end

endmodule

// File: tb/tb_encoder8to3_scan.sv
// Self-checking bench for encoder8to3_scan: directed table, hand-written
// stall/enable/reset sequences, and randomized vectors against a set-bit-list model.
module tb_encoder8to3_scan;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  encoder8to3_scan_if #(.IN_W(8), .OUT_W(3)) bus ();

  encoder8to3_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] d;
    int         nbeats;
    int         first_y;
    int         last_y;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list of set-bit positions in priority order, or one 0 for an empty vector.
  task automatic build_exp(input logic [7:0] v);
    exp_q.delete();
    if (v == 8'h00) begin
      exp_q.push_back(0);
    end else begin
`ifdef ENCODER_MSB_PRIORITY_EN
      for (int b = 7; b >= 0; b--) if (((int'(v) >> b) & 1) == 1) exp_q.push_back(b);
`else
      for (int b = 0; b < 8; b++) if (((int'(v) >> b) & 1) == 1) exp_q.push_back(b);
`endif
    end
  endtask

  function automatic logic [6:0] obs();
    return {bus.out_valid, bus.in_ready, bus.y, bus.last, bus.zero};
  endfunction

  function automatic logic [6:0] exp_beat(input int idx, input logic lst, input logic zro);
    return {1'b1, 1'b0, 3'(idx), lst, zro};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] v);
    en = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.d = v;
    #1;
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.d = 8'($urandom);
  endtask

  task automatic run_vector(input logic [7:0] v, input int stall_pct, input int en_pct,
                            output int cycles, output int first_y, output int last_y);
    logic hs;
    accept(v);
    build_exp(v);
    cycles = 0;
    first_y = -1;
    last_y = -1;
    while (exp_q.size() > 0 && cycles < 400) begin
      en = ($urandom_range(99) < en_pct);
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      bus.in_valid = 1'($urandom_range(1));
      bus.d = 8'($urandom);
      #1;
      if (en) begin
        check("beat", 32'(obs()), 32'(exp_beat(exp_q[0], exp_q.size() == 1, v == 8'h00)));
      end else begin
        check("en_low_idle_outs", 32'({bus.out_valid, bus.in_ready}), 32'd0);
      end
      hs = en && bus.out_ready;
      if (hs) begin
        if (first_y < 0) first_y = exp_q[0];
        last_y = exp_q[0];
      end
      step();
      cycles++;
      if (hs) void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0) check("scan_timeout", 32'(exp_q.size()), 32'd0);
    bus.in_valid = 1'b0;
    en = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check("back_to_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  initial begin
    int cyc, fy, ly, guard;

`ifdef ENCODER_MSB_PRIORITY_EN
    tbl[0] = '{8'h10, 1, 4, 4};
    tbl[1] = '{8'hA6, 4, 7, 1};
    tbl[2] = '{8'h00, 1, 0, 0};
    tbl[3] = '{8'hFF, 8, 7, 0};
    tbl[4] = '{8'h81, 2, 7, 0};
    tbl[5] = '{8'h80, 1, 7, 7};
`else
    tbl[0] = '{8'h10, 1, 4, 4};
    tbl[1] = '{8'hA6, 4, 1, 7};
    tbl[2] = '{8'h00, 1, 0, 0};
    tbl[3] = '{8'hFF, 8, 0, 7};
    tbl[4] = '{8'h81, 2, 0, 7};
    tbl[5] = '{8'h01, 1, 0, 0};
`endif

    rst_n = 1'b0;
    en = 1'b0;
    bus.in_valid = 1'b0;
    bus.d = 8'h00;
    bus.out_ready = 1'b0;
    step();
    check("reset_en_low", 32'(obs()), 32'd0);
    en = 1'b1;
    #1;
    check("reset_en_high", 32'(obs()), 32'b0100000);
    rst_n = 1'b1;
    step();
    check("post_reset_idle", 32'(obs()), 32'b0100000);

    // Directed table, no stalls: k beats in k cycles, then idle.
    for (int i = 0; i < 6; i++) begin
      run_vector(tbl[i].d, 0, 100, cyc, fy, ly);
      check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].nbeats));
      check($sformatf("tbl%0d_first_y", i), 32'(fy), 32'(tbl[i].first_y));
      check($sformatf("tbl%0d_last_y", i), 32'(ly), 32'(tbl[i].last_y));
    end

    // Backpressure on first beat, en drop at index 3, in_valid ignored during scan.
    accept(8'hFF);
    build_exp(8'hFF);
    for (int i = 0; i < 3; i++) begin
      bus.out_ready = 1'b0;
      #1;
      check("stall_hold", 32'(obs()), 32'(exp_beat(exp_q[0], 1'b0, 1'b0)));
      step();
    end
    guard = 0;
    while (exp_q[0] != 3 && guard < 10) begin
      bus.out_ready = 1'b1;
      #1;
      check("pre_en_drop", 32'(obs()), 32'(exp_beat(exp_q[0], 1'b0, 1'b0)));
      step();
      void'(exp_q.pop_front());
      guard++;
    end
    for (int i = 0; i < 2; i++) begin
      en = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("en_low_no_valid", 32'({bus.out_valid, bus.in_ready}), 32'd0);
      step();
    end
    en = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.d = 8'h55;
    #1;
    check("resume_y3", 32'(obs()), 32'(exp_beat(3, 1'b0, 1'b0)));
    step();
    bus.in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      bus.out_ready = 1'b1;
      #1;
      check("drain", 32'(obs()), 32'(exp_beat(exp_q[0], exp_q.size() == 1, 1'b0)));
      step();
      void'(exp_q.pop_front());
      guard++;
    end
    bus.out_ready = 1'b0;
    #1;
    check("no_accept_during_scan", 32'(obs()), 32'b0100000);

    // Reset in the middle of a scan discards remaining indices.
    accept(8'hF0);
    build_exp(8'hF0);
    bus.out_ready = 1'b1;
    #1;
    check("f0_first_beat", 32'(obs()), 32'(exp_beat(exp_q[0], 1'b0, 1'b0)));
    step();
    bus.out_ready = 1'b0;
    #1;
    check("f0_second_pending", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_scan_reset", 32'(obs()), 32'b0100000);
    step();
    rst_n = 1'b1;
    step();
    check("after_reset_release", 32'(obs()), 32'b0100000);
    run_vector(8'h01, 0, 100, cyc, fy, ly);
    check("post_reset_vec_y", 32'(fy), 32'd0);
    check("post_reset_vec_cycles", 32'(cyc), 32'd1);

    // Randomized vectors with stalls and enable drops.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] v;
      v = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
      run_vector(v, 30, 80, cyc, fy, ly);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
